mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates a single-port, byte-addressed, 16-bit main memory (combinational read, write on rising edge, no concurrent read/write) between the instruction-fetch and data-access requesters. It inserts a programmable access latency so the pipeline can exercise multi-cycle memory. It sequences every access as a single memory-enable cycle and returns read data through a registered, one-cycle ready pulse. It sits between the fetch/memory pipeline stages and the memory instance.

## Interface
- ADDR_WIDTH, 16, address width in bits; bit 0 is ignored by memory.
- LATENCY, 4, busy cycles per access; must be ≥1; memory enable fires in the last busy cycle.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  instruction read request; held with i_addr until i_ready.
- i_addr  in  ADDR_WIDTH  instruction address.
- i_ready  out  1  one-cycle pulse: instruction access complete, rdata valid.
- d_req  in  1  data request; held with d_wr/d_addr/d_wdata until d_ready.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  16  write data.
- d_ready  out  1  one-cycle pulse: data access complete.
- rdata  out  16  registered read data, valid only while a ready pulse is high.
- busy  out  1  high whenever state ≠ IDLE.
- mem_enable  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  latched access address.
- mem_wdata  out  16  latched write data.
- mem_rdata  in  16  memory read data; combinational, 0 when not reading.

## Operation
- States: IDLE, BUSY_I, BUSY_D. The down-counter cnt is wide enough for LATENCY-1.
- IDLE, one request pending: grant it.
  - Latch the address. For a data request, also latch wr and wdata.
  - Load cnt = LATENCY-1 and go to BUSY_I or BUSY_D.
- IDLE, both pending: round-robin.
  - The requester not granted last wins.
  - The last_grant flag resets to "I", so the first contention after reset goes to D.
- BUSY, cnt > 0: decrement. mem_enable = 0.
- BUSY, cnt = 0:
  - mem_enable = 1 and mem_wr = latched wr (always 0 for BUSY_I).
  - At the clock edge, capture mem_rdata into rdata; a write captures 0.
  - Set the matching ready flop, update last_grant, and go to IDLE.
- Ready pulses last exactly one cycle. i_ready and d_ready are never high together.
- A req still high in the cycle its own ready is high counts as a new request and is eligible for arbitration in that same IDLE cycle.
- Requests arriving while BUSY are not acknowledged. They wait and are arbitrated in the next IDLE cycle.
- mem_addr and mem_wdata hold their latched values until the next grant.
- Reset values:
  - state IDLE, cnt 0, last_grant I.
  - i_ready, d_ready, mem_enable, mem_wr, busy = 0.
  - rdata, mem_addr, mem_wdata = 0.
- Reset mid-access: abort immediately. No ready pulse is issued and no memory write occurs, including when rst coincides with the cnt = 0 cycle. mem_enable and mem_wr are forced to 0 during rst.

## Timing
- Cycle 0 is the first cycle a req is high while in IDLE. The grant is taken at the end of cycle 0.
- busy is high in cycles 1..LATENCY. mem_enable is high only in cycle LATENCY.
- ready and rdata are valid in cycle LATENCY+1, when the FSM is back in IDLE.
- A waiting requester can be granted in cycle LATENCY+1. Its mem_enable then falls in cycle 2·LATENCY+1.
- Peak throughput is one access per LATENCY+1 cycles.
- No combinational path exists from any request input to mem_enable or to the ready outputs.

## Test plan
- **Reset values:** assert rst for 2 cycles with i_req=d_req=1 → all outputs 0 and busy 0 throughout. After release, the first grant goes to D.
- **Single read, LATENCY=4:** mem[0x0008]=0xABCD; i_req=1, i_addr=0x0010 at cycle 0 → mem_enable only in cycle 4 with mem_addr 0x0010 and mem_wr 0. In cycle 5, i_ready=1 and rdata=0xABCD.
- **Write then read back:** d write with addr 0x0020, data 0x1234 → mem_wr=1 in cycle 4, d_ready in cycle 5. A following d read of 0x0020 returns rdata=0x1234 with d_ready in cycle 10.
- **Contention alternation:** hold i_req and d_req high continuously from reset → grants go D, I, D, I. Ready pulses alternate every 5 cycles. Both readies are never high in the same cycle.
- **Reset mid-write:** d write to 0x0030 (mem holds 0x5555), rst in cycle 4 → no d_ready, mem_enable 0, and a later read of 0x0030 returns 0x5555.
- **LATENCY=1 back-to-back:** i_req held high → mem_enable in cycles 1, 3, 5 and i_ready in cycles 2, 4, 6, each pulse with the correct data.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of request/response and memory-side signals between
//               the fetch/data requesters, the arbiter and the memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);
    // instruction-fetch requester
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ready;
    // data requester
    logic                  d_req;
    logic                  d_wr;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [15:0]           d_wdata;
    logic                  d_ready;
    // shared response / status
    logic [15:0]           rdata;
    logic                  busy;
    // memory side
    logic                  mem_enable;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;
    logic [15:0]           mem_rdata;

    // arbiter view
    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_ready, d_ready, rdata, busy,
               mem_enable, mem_wr, mem_addr, mem_wdata
    );

    // requesters + memory view
    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_ready, d_ready, rdata, busy,
               mem_enable, mem_wr, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter between instruction fetch and data access
//               for a single-port 16-bit memory, with programmable access
//               latency, a single enable cycle per access and a registered
//               one-cycle ready pulse carrying the read data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,  // must match the interface instance
    parameter int LATENCY    = 4    // busy cycles per access, >= 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mem_arbiter_if.slave    bus
);

    // Counter just wide enough to hold LATENCY-1 (at least one bit).
    localparam int                CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_LOAD = CNT_W'(LATENCY - 1);

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_BUSY_I = 2'd1;
    localparam logic [1:0] C_BUSY_D = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_last_d;   // 1 = data side was granted last
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic [15:0]           r_rdata;
    logic                  r_i_ready;
    logic                  r_d_ready;

    logic                  w_busy;
    logic                  w_last_cycle;
    logic                  w_grant_d;
    logic                  w_grant_i;

    // Grant decode: data wins when alone, or on contention when instruction
    // side was served last. Only consulted while idle.
    always_comb begin
        w_busy       = (r_state != C_IDLE);
        w_last_cycle = w_busy && (r_cnt == '0);
        w_grant_d    = bus.d_req && (!bus.i_req || !r_last_d);
        w_grant_i    = bus.i_req && !w_grant_d;
    end

    // Access sequencer: grant, count down the latency, complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= C_IDLE;
            r_cnt     <= '0;
            r_last_d  <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
        end else begin
            // ready flops pulse for exactly one cycle
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (w_grant_d) begin
                        r_addr  <= bus.d_addr;
                        r_wr    <= bus.d_wr;
                        r_wdata <= bus.d_wdata;
                        r_cnt   <= C_CNT_LOAD;
                        r_state <= C_BUSY_D;
                    end else if (w_grant_i) begin
                        // write data keeps its previous value on fetches
                        r_addr  <= bus.i_addr;
                        r_wr    <= 1'b0;
                        r_cnt   <= C_CNT_LOAD;
                        r_state <= C_BUSY_I;
                    end
                end
                C_BUSY_I, C_BUSY_D: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        // memory read data is only meaningful for reads
                        r_rdata   <= r_wr ? 16'h0000 : bus.mem_rdata;
                        r_i_ready <= (r_state == C_BUSY_I);
                        r_d_ready <= (r_state == C_BUSY_D);
                        r_last_d  <= (r_state == C_BUSY_D);
                        r_state   <= C_IDLE;
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    // Memory strobes come from registered state only; reset kills them at
    // once so an access aborted on its final cycle never writes.
    always_comb begin
        bus.mem_enable = w_last_cycle && !rst;
        bus.mem_wr     = w_last_cycle && !rst && r_wr;
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.rdata     = r_rdata;
    assign bus.i_ready   = r_i_ready;
    assign bus.d_ready   = r_d_ready;
    assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter. Two instances (LATENCY 4
//               and 1) each with a behavioural memory; directed stimulus
//               pushes expected memory-enable and ready events, negedge
//               monitors pop and compare them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 16;

    typedef struct {
        int          cyc;
        bit          is_d;
        logic [15:0] data;
    } rsp_t;

    typedef struct {
        int          cyc;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    rsp_t rq4[$];
    rsp_t rq1[$];
    mev_t mq4[$];
    mev_t mq1[$];

    logic [15:0] mem4 [0:127];
    logic [15:0] mem1 [0:127];

    mem_arbiter_if #(.ADDR_WIDTH(AW)) bus4();
    mem_arbiter_if #(.ADDR_WIDTH(AW)) bus1();

    mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural memories: combinational read, write on rising edge
    assign bus4.mem_rdata = (bus4.mem_enable && !bus4.mem_wr) ? mem4[bus4.mem_addr[7:1]] : 16'h0000;
    assign bus1.mem_rdata = (bus1.mem_enable && !bus1.mem_wr) ? mem1[bus1.mem_addr[7:1]] : 16'h0000;

    always @(posedge clk) begin
        if (bus4.mem_enable && bus4.mem_wr) mem4[bus4.mem_addr[7:1]] <= bus4.mem_wdata;
        if (bus1.mem_enable && bus1.mem_wr) mem1[bus1.mem_addr[7:1]] <= bus1.mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // compare one instance's outputs against its expectation queues
    task automatic monitor(input bit one, input logic ir, input logic dr, input logic [15:0] rd,
                           input logic me, input logic mw, input logic [15:0] ma,
                           input logic [15:0] mwd);
        rsp_t r;
        mev_t m;
        chk(one ? "l1_ready_excl" : "l4_ready_excl", {31'b0, ir & dr}, 32'h0);
        if (me === 1'b1) begin
            if ((one ? mq1.size() : mq4.size()) == 0) begin
                chk(one ? "l1_unexpected_mem_enable" : "l4_unexpected_mem_enable", 32'h1, 32'h0);
            end else begin
                m = one ? mq1.pop_front() : mq4.pop_front();
                chk(one ? "l1_mem_cycle" : "l4_mem_cycle", cyc, m.cyc);
                chk(one ? "l1_mem_wr" : "l4_mem_wr", {31'b0, mw}, {31'b0, m.wr});
                chk(one ? "l1_mem_addr" : "l4_mem_addr", {16'b0, ma}, {16'b0, m.addr});
                if (m.wr) chk(one ? "l1_mem_wdata" : "l4_mem_wdata", {16'b0, mwd}, {16'b0, m.wdata});
            end
        end
        if (ir === 1'b1 || dr === 1'b1) begin
            if ((one ? rq1.size() : rq4.size()) == 0) begin
                chk(one ? "l1_unexpected_ready" : "l4_unexpected_ready", 32'h1, 32'h0);
            end else begin
                r = one ? rq1.pop_front() : rq4.pop_front();
                chk(one ? "l1_ready_cycle" : "l4_ready_cycle", cyc, r.cyc);
                chk(one ? "l1_ready_side" : "l4_ready_side", {31'b0, dr}, {31'b0, r.is_d});
                chk(one ? "l1_rdata" : "l4_rdata", {16'b0, rd}, {16'b0, r.data});
            end
        end
    endtask

    always @(negedge clk) begin
        monitor(1'b0, bus4.i_ready, bus4.d_ready, bus4.rdata, bus4.mem_enable, bus4.mem_wr,
                bus4.mem_addr, bus4.mem_wdata);
        monitor(1'b1, bus1.i_ready, bus1.d_ready, bus1.rdata, bus1.mem_enable, bus1.mem_wr,
                bus1.mem_addr, bus1.mem_wdata);
    end

    task automatic push4(input int mcyc, input bit is_d, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [15:0] exp);
        mev_t m;
        rsp_t r;
        m.cyc = mcyc; m.wr = wr; m.addr = addr; m.wdata = wd;
        r.cyc = mcyc + 1; r.is_d = is_d; r.data = exp;
        mq4.push_back(m);
        rq4.push_back(r);
    endtask

    task automatic push1(input int mcyc, input logic [15:0] addr, input logic [15:0] exp);
        mev_t m;
        rsp_t r;
        m.cyc = mcyc; m.wr = 1'b0; m.addr = addr; m.wdata = 16'h0;
        r.cyc = mcyc + 1; r.is_d = 1'b0; r.data = exp;
        mq1.push_back(m);
        rq1.push_back(r);
    endtask

    // one complete access on the LATENCY=4 instance, starting this cycle
    task automatic access4(input bit is_d, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [15:0] exp);
        int c0;
        c0 = cyc;
        if (is_d) begin
            bus4.d_req = 1'b1; bus4.d_wr = wr; bus4.d_addr = addr; bus4.d_wdata = wd;
        end else begin
            bus4.i_req = 1'b1; bus4.i_addr = addr;
        end
        push4(c0 + 4, is_d, wr, addr, wd, exp);
        repeat (5) tick();
        if (is_d) bus4.d_req = 1'b0;
        else      bus4.i_req = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name, input bit one);
        if (one)
            chk(name, {24'b0, bus1.i_ready, bus1.d_ready, bus1.mem_enable, bus1.mem_wr, bus1.busy, 3'b0}
                      | {bus1.rdata, 16'b0} | {16'b0, bus1.mem_addr} | {16'b0, bus1.mem_wdata}, 32'h0);
        else
            chk(name, {24'b0, bus4.i_ready, bus4.d_ready, bus4.mem_enable, bus4.mem_wr, bus4.busy, 3'b0}
                      | {bus4.rdata, 16'b0} | {16'b0, bus4.mem_addr} | {16'b0, bus4.mem_wdata}, 32'h0);
    endtask

    initial begin
        int r0;
        int c0;

        for (int i = 0; i < 128; i++) begin
            mem4[i] <= 16'h0000;
            mem1[i] <= 16'h0000;
        end
        #0;
        mem4[8'h08] <= 16'hABCD;   // addr 0x0010
        mem4[8'h20] <= 16'h2222;   // addr 0x0040
        mem4[8'h18] <= 16'h5555;   // addr 0x0030
        mem1[8'h08] <= 16'h0A0A;   // addr 0x0010
        mem1[8'h09] <= 16'h0B0B;   // addr 0x0012
        mem1[8'h0A] <= 16'h0C0C;   // addr 0x0014

        rst = 1'b1;
        bus4.i_req = 1'b1; bus4.i_addr = 16'h0010;
        bus4.d_req = 1'b1; bus4.d_wr = 1'b0; bus4.d_addr = 16'h0040; bus4.d_wdata = 16'h0000;
        bus1.i_req = 1'b0; bus1.i_addr = 16'h0000;
        bus1.d_req = 1'b0; bus1.d_wr = 1'b0; bus1.d_addr = 16'h0000; bus1.d_wdata = 16'h0000;

        // reset with both requests pending: everything stays low
        tick();
        @(negedge clk);
        chk_reset_outputs("reset_outputs_l4_c1", 1'b0);
        chk_reset_outputs("reset_outputs_l1_c1", 1'b1);
        tick();
        @(negedge clk);
        chk_reset_outputs("reset_outputs_l4_c2", 1'b0);
        chk_reset_outputs("reset_outputs_l1_c2", 1'b1);
        tick();
        rst = 1'b0;

        // contention from reset: D, I, D, I every 5 cycles
        r0 = cyc;
        push4(r0 + 4,  1'b1, 1'b0, 16'h0040, 16'h0, 16'h2222);
        push4(r0 + 9,  1'b0, 1'b0, 16'h0010, 16'h0, 16'hABCD);
        push4(r0 + 14, 1'b1, 1'b0, 16'h0040, 16'h0, 16'h2222);
        push4(r0 + 19, 1'b0, 1'b0, 16'h0010, 16'h0, 16'hABCD);
        @(negedge clk);
        chk("busy_idle_after_reset", {31'b0, bus4.busy}, 32'h0);
        while (cyc < r0 + 15) tick();
        bus4.d_req = 1'b0;
        while (cyc < r0 + 20) tick();
        bus4.i_req = 1'b0;
        repeat (2) tick();

        // single fetch, then write followed by read-back
        access4(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hABCD);
        tick();
        access4(1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000);
        access4(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234);
        repeat (2) tick();

        // reset landing on the enable cycle of a write
        c0 = cyc;
        bus4.d_req = 1'b1; bus4.d_wr = 1'b1; bus4.d_addr = 16'h0030; bus4.d_wdata = 16'hDEAD;
        while (cyc < c0 + 4) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_mem_enable", {31'b0, bus4.mem_enable}, 32'h0);
        chk("rst_abort_mem_wr", {31'b0, bus4.mem_wr}, 32'h0);
        tick();
        rst = 1'b0;
        bus4.d_req = 1'b0; bus4.d_wr = 1'b0;
        @(negedge clk);
        chk("rst_abort_no_d_ready", {31'b0, bus4.d_ready}, 32'h0);
        chk("rst_abort_busy", {31'b0, bus4.busy}, 32'h0);
        tick();
        access4(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555);
        repeat (2) tick();

        // LATENCY=1: fetch held high, a new address offered in each ready cycle
        c0 = cyc;
        bus1.i_req = 1'b1; bus1.i_addr = 16'h0010;
        push1(c0 + 1, 16'h0010, 16'h0A0A);
        push1(c0 + 3, 16'h0012, 16'h0B0B);
        push1(c0 + 5, 16'h0014, 16'h0C0C);
        repeat (2) tick();
        bus1.i_addr = 16'h0012;
        repeat (2) tick();
        bus1.i_addr = 16'h0014;
        repeat (2) tick();
        bus1.i_req = 1'b0;
        repeat (4) tick();

        @(negedge clk);
        chk("leftover_rsp_l4", rq4.size(), 32'h0);
        chk("leftover_mem_l4", mq4.size(), 32'h0);
        chk("leftover_rsp_l1", rq1.size(), 32'h0);
        chk("leftover_mem_l1", mq1.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
